serial_cascade_comparator: RTL and testbench
============================================

// Module: serial_cascade_comparator
// PURPOSE
//   Sequential wide-operand magnitude comparator placed upstream of the 6-bit ripple comparator stage.
//   Streams latched A/B operands chunk-by-chunk, LSB chunk first, through one chunk comparator cell.
//   The previous chunk's registered gt/lt/eq result drives the cell's cascade inputs.
//   Trades NUM_CHUNKS cycles of latency for one comparator cell; valid/ready on both sides.
// PARAMETERS
//   CHUNK_W     6   bits per chunk; width of the chunk comparator cell
//   NUM_CHUNKS  4   chunks per operand; operand width W = CHUNK_W*NUM_CHUNKS (>=1)
// PORTS
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   in_valid   in   1  operand/cascade inputs valid
//   in_ready   out  1  block can accept; high only in IDLE
//   A          in   W  operand A, unsigned
//   B          in   W  operand B, unsigned
//   gti        in   1  external cascade in: lower-order stage says A>B
//   lti        in   1  external cascade in: lower-order stage says A<B
//   eqi        in   1  external cascade in: lower-order stage says A==B
//   out_valid  out  1  result valid; held until out_ready
//   out_ready  in   1  consumer accepts result
//   gto        out  1  A > B
//   lto        out  1  A < B
//   eqo        out  1  A == B
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, out_valid=0, gto=0, lto=0, eqo=1, shift regs/counter cleared.
//   FSM IDLE -> RUN on in_valid&&in_ready; latch A, B, cascade at that edge (edge E0).
//   Cascade normalisation at latch: priority gti > lti > eqi; all zero -> treat as eqi=1.
//   RUN: one chunk per edge, index k=0..NUM_CHUNKS-1, LSB chunk first. Chunk compare rule:
//     A_k>B_k -> gt; A_k<B_k -> lt; equal -> pass running (cascade) result through unchanged.
//   Running result is registered; chunk 0 uses the latched external cascade.
//   Edge E(NUM_CHUNKS): last chunk done; state -> DONE; gto/lto/eqo loaded; out_valid=1.
//   Latency: out_valid rises exactly NUM_CHUNKS cycles after the accept edge.
//   DONE: out_valid and gto/lto/eqo held stable while out_ready=0.
//   out_valid&&out_ready -> IDLE next edge; in_ready=1 from then on.
//   Throughput: one compare per NUM_CHUNKS+2 cycles.
//   gto/lto/eqo are exactly one-hot whenever out_valid=1.
//   Outside DONE they hold the last delivered result; reset values until the first result.
//   in_ready is combinational (state==IDLE); in_valid outside IDLE is ignored.
//   A/B may change after accept without effect.
//   Chunk counter saturates/clears on DONE entry; no wrap into a second pass.
//   rst_n low mid-RUN or in DONE: operation discarded, no out_valid, all outputs to reset values at once.
//   NUM_CHUNKS=1: single RUN cycle; same rules apply.
// STRUCTURE
//   Shared package cmp_pkg:
//     typedef enum {CMP_EQ, CMP_GT, CMP_LT} cmp_res_t;
//     typedef enum {S_IDLE, S_RUN, S_DONE} cmp_state_t;
//     helper function to normalise the gti/lti/eqi triple into cmp_res_t.
//   Sub-module chunk_compare_cell: combinational CHUNK_W-bit compare with gti/lti/eqi cascade.
//     Semantics identical to the existing ripple comparator stage.
//   Top: FSM, chunk counter, two right-shift operand registers, running-result register, output regs.
// TESTING (defaults CHUNK_W=6, NUM_CHUNKS=4, W=24)
//   1 A=15, B=0, eqi=1 -> out_valid exactly 4 cycles after accept; gto=1, lto=0, eqo=0.
//   2 A=B=24'hABCDEF: eqi=1 -> eqo=1; repeat with gti=1 -> gto=1; with lti=1 -> lto=1.
//   3 A=24'h040000, B=24'h03FFFF, eqi=1 -> gto=1 (high chunk overrides three lower lt chunks).
//   4 Result ready, out_ready=0 for 3 cycles, in_valid=1 throughout:
//     -> out_valid/outputs stable, in_ready=0, no new accept; out_ready=1 -> in_ready=1 next cycle.
//   5 rst_n=0 during 2nd RUN cycle -> immediately gto=0, lto=0, eqo=1, out_valid=0;
//     after release in_ready=1 and no result appears.
//   6 gti=lti=eqi=0, A=B=24'hFFFFFF -> eqo=1.
//     gti=lti=1, A=B -> gto=1.
//     A=0, B=1, gti=1 -> lto=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and cascade helper for the serial cascade comparator.
package cmp_pkg;

    localparam int unsigned CHUNK_W_DEF    = 6;
    localparam int unsigned NUM_CHUNKS_DEF = 4;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_GT = 2'd1,
        CMP_LT = 2'd2
    } cmp_res_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } cmp_state_t;

    // Priority gt > lt > eq; an all-zero triple is read as equal.
    function automatic cmp_res_t norm_cascade(input logic gti, input logic lti, input logic eqi);
        cmp_res_t res;
        if (gti)      res = CMP_GT;
        else if (lti) res = CMP_LT;
        else if (eqi) res = CMP_EQ;
        else          res = CMP_EQ;
        return res;
    endfunction

endpackage

// File: rtl/chunk_compare_cell.sv
// Combinational CHUNK_W-bit magnitude compare with gt/lt/eq cascade inputs.
module chunk_compare_cell #(
    parameter int unsigned CHUNK_W = 6
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               gti,
    input  logic               lti,
    input  logic               eqi,
    output logic               gt_c,
    output logic               lt_c,
    output logic               eq_c
);

    // Unequal chunk decides; an equal chunk forwards the lower-order verdict.
    always_comb begin
        gt_c = gti;
        lt_c = lti;
        eq_c = eqi;
        if (a > b) begin
            gt_c = 1'b1;
            lt_c = 1'b0;
            eq_c = 1'b0;
        end else if (a < b) begin
            gt_c = 1'b0;
            lt_c = 1'b1;
            eq_c = 1'b0;
        end
    end

endmodule

// File: rtl/serial_cascade_comparator.sv
// Wide magnitude comparator that streams operands LSB chunk first through one
// chunk compare cell, carrying the running verdict in a register.
module serial_cascade_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned CHUNK_W    = CHUNK_W_DEF,
    parameter int unsigned NUM_CHUNKS = NUM_CHUNKS_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] A,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] B,
    input  logic                          gti,
    input  logic                          lti,
    input  logic                          eqi,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          gto,
    output logic                          lto,
    output logic                          eqo
);

    localparam int unsigned W     = CHUNK_W * NUM_CHUNKS;
    localparam int unsigned CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);

    cmp_state_t       state;
    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic [CNT_W-1:0] cnt;
    cmp_res_t         run_res;

    logic     cell_gt_c;
    logic     cell_lt_c;
    logic     cell_eq_c;
    cmp_res_t cell_res_c;

    assign in_ready = (state == S_IDLE);

    chunk_compare_cell #(
        .CHUNK_W (CHUNK_W)
    ) u_cell (
        .a    (a_sr[CHUNK_W-1:0]),
        .b    (b_sr[CHUNK_W-1:0]),
        .gti  (run_res == CMP_GT),
        .lti  (run_res == CMP_LT),
        .eqi  (run_res == CMP_EQ),
        .gt_c (cell_gt_c),
        .lt_c (cell_lt_c),
        .eq_c (cell_eq_c)
    );

    assign cell_res_c = norm_cascade(cell_gt_c, cell_lt_c, cell_eq_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            cnt       <= '0;
            run_res   <= CMP_EQ;
            out_valid <= 1'b0;
            gto       <= 1'b0;
            lto       <= 1'b0;
            eqo       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sr    <= A;
                        b_sr    <= B;
                        run_res <= norm_cascade(gti, lti, eqi);
                        cnt     <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr    <= a_sr >> CHUNK_W;
                    b_sr    <= b_sr >> CHUNK_W;
                    run_res <= cell_res_c;
                    if (cnt == LAST_IDX) begin
                        cnt       <= '0;
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        gto       <= (cell_res_c == CMP_GT);
                        lto       <= (cell_res_c == CMP_LT);
                        eqo       <= (cell_res_c == CMP_EQ);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cascade_comparator.sv
// Directed and random checks of serial_cascade_comparator against a whole-operand model.
module tb_serial_cascade_comparator;

    localparam int unsigned CHUNK_W    = 6;
    localparam int unsigned NUM_CHUNKS = 4;
    localparam int unsigned W          = CHUNK_W * NUM_CHUNKS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         gti, lti, eqi;
    logic         out_valid;
    logic         out_ready;
    logic         gto, lto, eqo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_cascade_comparator #(
        .CHUNK_W    (CHUNK_W),
        .NUM_CHUNKS (NUM_CHUNKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .gti       (gti),
        .lti       (lti),
        .eqi       (eqi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gto       (gto),
        .lto       (lto),
        .eqo       (eqo)
    );

    // Whole-operand reference: magnitude decides, ties fall back to the prioritised cascade.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic g, input logic l, input logic e);
        logic [2:0] r;
        if (a > b)      r = 3'b100;
        else if (a < b) r = 3'b010;
        else if (g)     r = 3'b100;
        else if (l)     r = 3'b010;
        else if (e)     r = 3'b001;
        else            r = 3'b001;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic g, input logic l, input logic e, input int hold);
        logic [2:0] exp;
        int cyc;
        exp = model(a, b, g, l, e);
        @(negedge clk);
        check({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
        A = a; B = b; gti = g; lti = l; eqi = e;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "/in_ready_run"}, 32'(in_ready), 32'd0);
        // keep offering different operands; they must be ignored
        A = W'($urandom); B = W'($urandom);
        gti = 1'($urandom); lti = 1'($urandom); eqi = 1'($urandom);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "/latency"}, 32'(cyc), 32'(NUM_CHUNKS));
        check({tag, "/result"}, 32'({gto, lto, eqo}), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "/hold_result"}, 32'({gto, lto, eqo}), 32'(exp));
            check({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check({tag, "/drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, "/drain_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "/kept_result"}, 32'({gto, lto, eqo}), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0; B = '0;
        gti = 1'b0; lti = 1'b0; eqi = 1'b1;
        repeat (3) @(negedge clk);
        check("reset/outs", 32'({out_valid, gto, lto, eqo}), 32'b0001);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset/in_ready", 32'(in_ready), 32'd1);
        check("reset/outs_after", 32'({out_valid, gto, lto, eqo}), 32'b0001);

        run_one("t1_15_gt_0", 24'd15, 24'd0, 1'b0, 1'b0, 1'b1, 0);
        run_one("t2_eq_eqi", 24'hABCDEF, 24'hABCDEF, 1'b0, 1'b0, 1'b1, 1);
        run_one("t2_eq_gti", 24'hABCDEF, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 0);
        run_one("t2_eq_lti", 24'hABCDEF, 24'hABCDEF, 1'b0, 1'b1, 1'b0, 0);
        run_one("t3_high_chunk", 24'h040000, 24'h03FFFF, 1'b0, 1'b0, 1'b1, 0);
        run_one("t4_backpressure", 24'h000123, 24'h800000, 1'b0, 1'b0, 1'b1, 3);
        run_one("t6_all_zero_casc", 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 0);
        run_one("t6_gti_lti", 24'h5A5A5A, 24'h5A5A5A, 1'b1, 1'b1, 1'b0, 0);
        run_one("t6_a0_b1_gti", 24'd0, 24'd1, 1'b1, 1'b0, 1'b0, 0);

        // reset during the second RUN cycle discards the operation
        @(negedge clk);
        A = 24'hFFFFFF; B = 24'd0; gti = 1'b0; lti = 1'b0; eqi = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5/outs_in_reset", 32'({out_valid, gto, lto, eqo}), 32'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5/in_ready_after", 32'(in_ready), 32'd1);
        for (int i = 0; i < NUM_CHUNKS + 3; i++) begin
            @(negedge clk);
            check("t5/no_result", 32'({out_valid, gto, lto, eqo}), 32'b0001);
        end

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (n % 4 == 0) rb = ra;
            else if (n % 4 == 1) rb = ra ^ (W'(1) << $urandom_range(W - 1, 0));
            run_one($sformatf("rand%0d", n), ra, rb, 1'($urandom), 1'($urandom),
                    1'($urandom), int'($urandom_range(2, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
